// File: rtl/fetch_unit.sv
// fetch_unit: RV32I instruction-fetch stage.
// Owns the fetch PC and issues one instruction-memory request at a time.
// Returned instructions go into a small {pc, instr} FIFO whose head feeds IF/ID.
// Handshake: a request transfers when imem_req && imem_ready. Once raised,
// imem_req/imem_addr hold until accepted, and only a redirect withdraws them.
// Each accepted request gets exactly one in-order imem_rvalid pulse.
module fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
   parameter int          BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        Stall_F,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        validF,
   output logic [31:0] instrF,
   output logic [31:0] PCF,
   output logic [31:0] PCp4F
);

   localparam int          PW      = $clog2(BUF_DEPTH);
   localparam int          CW      = $clog2(BUF_DEPTH + 1);
   localparam logic [CW:0] DEPTH_C = (CW+1)'(BUF_DEPTH);

   logic [31:0]   fpc;        // next address to request
   logic [31:0]   reqPc;      // address of the request currently outstanding
   logic          outFlag;    // one request in flight
   logic          dropFlag;   // in-flight response belongs to a squashed path
   logic [PW-1:0] rdPtr;
   logic [PW-1:0] wrPtr;
   logic [CW-1:0] count;
   logic [31:0]   bufPc    [BUF_DEPTH];
   logic [31:0]   bufInstr [BUF_DEPTH];

   logic          pop;
   logic          push;
   logic          accept;
   logic          slotFree;
   logic [CW:0]   occupancy;
   logic [31:0]   headPc;

   // Issue decision, FIFO push/pop strobes and the IF/ID-facing outputs.
   // A slot being popped this cycle counts as free, so a 1-cycle memory keeps
   // the pipe full; the in-flight request already owns one slot.
   always_comb begin
      validF    = (count != '0) && !redirect;
      pop       = validF && !Stall_F;
      occupancy = {1'b0, count} + (CW+1)'(outFlag) - (CW+1)'(pop);
      slotFree  = occupancy < DEPTH_C;
      imem_req  = rst_n && !redirect && (!outFlag || (imem_rvalid && !dropFlag)) && slotFree;
      imem_addr = fpc;
      accept    = imem_req && imem_ready;
      push      = imem_rvalid && outFlag && !dropFlag && !redirect;
      headPc    = bufPc[rdPtr];
      instrF    = validF ? bufInstr[rdPtr] : NOP_INSTR;
      PCF       = validF ? headPc : '0;
      PCp4F     = validF ? headPc + 32'd4 : '0;
   end

   // Fetch PC, outstanding/drop tracking and FIFO bookkeeping; redirect wins over all.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fpc      <= RESET_PC;
         reqPc    <= RESET_PC;
         outFlag  <= 1'b0;
         dropFlag <= 1'b0;
         rdPtr    <= '0;
         wrPtr    <= '0;
         count    <= '0;
      end else if (redirect) begin
         fpc   <= {redirect_pc[31:2], 2'b00};
         rdPtr <= '0;
         wrPtr <= '0;
         count <= '0;
         if (outFlag && !imem_rvalid) begin
            dropFlag <= 1'b1;
         end else begin
            outFlag  <= 1'b0;
            dropFlag <= 1'b0;
         end
      end else begin
         if (accept) begin
            outFlag <= 1'b1;
            fpc     <= fpc + 32'd4;
            reqPc   <= fpc;
         end else if (imem_rvalid) begin
            outFlag <= 1'b0;
         end
         if (imem_rvalid && dropFlag) dropFlag <= 1'b0;
         if (push) wrPtr <= wrPtr + 1'b1;
         if (pop)  rdPtr <= rdPtr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
      end
   end

   // FIFO storage: capture the request PC alongside the returned instruction.
   always_ff @(posedge clk) begin
      if (push) begin
         bufPc[wrPtr]    <= reqPc;
         bufInstr[wrPtr] <= imem_rdata;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with a variable-latency memory model.
module tb_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam int          DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        Stall_F = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready = 1'b1;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        validF;
   logic [31:0] instrF;
   logic [31:0] PCF;
   logic [31:0] PCp4F;

   int nTests = 0;
   int nFail  = 0;
   logic [31:0] expQ[$];

   fetch_unit #(.RESET_PC(32'h0), .NOP_INSTR(NOP), .BUF_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .Stall_F(Stall_F), .redirect(redirect),
      .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .validF(validF), .instrF(instrF), .PCF(PCF), .PCp4F(PCp4F)
   );

   // clock / reset block
   always #5 clk = ~clk;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return a ^ 32'hC0DE_0003;
   endfunction

   // memory model: one pending request, response memLat cycles after acceptance
   int          memLat = 1;
   logic        memPend;
   int          memCnt;
   logic [31:0] memAddr;
   int          accCnt = 0;

   assign imem_rvalid = memPend && (memCnt == 0);
   assign imem_rdata  = instr_of(memAddr);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         memPend <= 1'b0;
         memCnt  <= 0;
         memAddr <= '0;
      end else if (imem_req && imem_ready) begin
         memPend <= 1'b1;
         memAddr <= imem_addr;
         memCnt  <= memLat - 1;
      end else if (memPend && memCnt == 0) begin
         memPend <= 1'b0;
      end else if (memPend) begin
         memCnt <= memCnt - 1;
      end
   end

   always @(posedge clk) begin
      if (rst_n && imem_req && imem_ready) accCnt <= accCnt + 1;
   end

   task automatic test_reset;
      rst_n = 1'b0; Stall_F = 1'b0; redirect = 1'b0; imem_ready = 1'b1; memLat = 1;
      repeat (3) @(negedge clk);
      #1;
      if (imem_req !== 1'b0) begin nFail++; $display("FAIL reset_req: got %b want 0", imem_req); end
      nTests++;
      if (validF !== 1'b0) begin nFail++; $display("FAIL reset_valid: got %b want 0", validF); end
      nTests++;
      if (instrF !== NOP) begin nFail++; $display("FAIL reset_instr: got %h want %h", instrF, NOP); end
      nTests++;
      if ({PCF, PCp4F} !== 64'h0) begin nFail++; $display("FAIL reset_pc: got %h/%h want 0/0", PCF, PCp4F); end
      nTests++;
   endtask

   task automatic test_stream;
      logic [31:0] expPc;
      for (int k = 0; k < 8; k++) expQ.push_back(32'(4 * k));
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (i > 0) @(negedge clk);
         #1;
         if ({imem_req, imem_addr} !== {1'b1, 32'(4 * i)}) begin
            nFail++; $display("FAIL stream_req[%0d]: got %b/%h want 1/%h", i, imem_req, imem_addr, 32'(4 * i));
         end
         nTests++;
         if (i < 2) begin
            if (validF !== 1'b0) begin nFail++; $display("FAIL stream_early_valid[%0d]: got %b want 0", i, validF); end
            nTests++;
         end else begin
            expPc = expQ.pop_front();
            if ({validF, PCF, PCp4F, instrF} !== {1'b1, expPc, expPc + 32'd4, instr_of(expPc)}) begin
               nFail++; $display("FAIL stream_out[%0d]: got v=%b pc=%h p4=%h i=%h want pc=%h", i, validF, PCF, PCp4F, instrF, expPc);
            end
            nTests++;
         end
      end
   endtask

   task automatic test_stall;
      int acc0;
      logic [31:0] expPc;
      @(negedge clk);
      Stall_F = 1'b1;
      acc0 = accCnt;
      for (int i = 0; i < 6; i++) begin
         if (i > 0) @(negedge clk);
         #1;
         if ({validF, PCF, instrF} !== {1'b1, 32'h20, instr_of(32'h20)}) begin
            nFail++; $display("FAIL stall_hold[%0d]: got v=%b pc=%h i=%h want pc=00000020", i, validF, PCF, instrF);
         end
         nTests++;
      end
      if (imem_req !== 1'b0) begin nFail++; $display("FAIL stall_req_stop: got %b want 0", imem_req); end
      nTests++;
      @(negedge clk);
      if (accCnt - acc0 > DEPTH + 1) begin nFail++; $display("FAIL stall_accepts: got %0d want <= %0d", accCnt - acc0, DEPTH + 1); end
      nTests++;
      Stall_F = 1'b0;
      for (int k = 0; k < 6; k++) expQ.push_back(32'h20 + 32'(4 * k));
      for (int i = 0; i < 6; i++) begin
         if (i > 0) @(negedge clk);
         #1;
         expPc = expQ.pop_front();
         if ({validF, PCF, instrF} !== {1'b1, expPc, instr_of(expPc)}) begin
            nFail++; $display("FAIL stall_resume[%0d]: got v=%b pc=%h i=%h want pc=%h", i, validF, PCF, instrF, expPc);
         end
         nTests++;
      end
   endtask

   task automatic test_redirect_drop;
      @(negedge clk);
      rst_n = 1'b0; Stall_F = 1'b0; imem_ready = 1'b1;
      repeat (2) @(negedge clk);
      memLat = 3;
      rst_n = 1'b1; redirect = 1'b1; redirect_pc = 32'h20;
      #1;
      if (imem_req !== 1'b0) begin nFail++; $display("FAIL redir_c0_req: got %b want 0", imem_req); end
      nTests++;
      @(negedge clk); redirect = 1'b0; #1;
      if ({imem_req, imem_addr} !== {1'b1, 32'h20}) begin nFail++; $display("FAIL redir_req20: got %b/%h want 1/00000020", imem_req, imem_addr); end
      nTests++;
      @(negedge clk); redirect = 1'b1; redirect_pc = 32'h100; #1;
      if ({validF, imem_req} !== 2'b00) begin nFail++; $display("FAIL redir_cycle: got v=%b req=%b want 0/0", validF, imem_req); end
      nTests++;
      @(negedge clk); redirect = 1'b0; #1;
      if (imem_req !== 1'b0) begin nFail++; $display("FAIL redir_wait1: got req=%b want 0", imem_req); end
      nTests++;
      @(negedge clk); #1;
      if ({imem_req, validF} !== 2'b00) begin nFail++; $display("FAIL redir_dropcyc: got req=%b v=%b want 0/0", imem_req, validF); end
      nTests++;
      @(negedge clk); #1;
      if ({imem_req, imem_addr, validF} !== {1'b1, 32'h100, 1'b0}) begin
         nFail++; $display("FAIL redir_req100: got %b/%h v=%b want 1/00000100 v=0", imem_req, imem_addr, validF);
      end
      nTests++;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         if (validF !== 1'b0) begin nFail++; $display("FAIL redir_nostale[%0d]: got v=%b pc=%h want v=0", i, validF, PCF); end
         nTests++;
      end
      @(negedge clk); #1;
      if ({validF, PCF, PCp4F, instrF} !== {1'b1, 32'h100, 32'h104, instr_of(32'h100)}) begin
         nFail++; $display("FAIL redir_first: got v=%b pc=%h p4=%h i=%h want pc=00000100", validF, PCF, PCp4F, instrF);
      end
      nTests++;
   endtask

   task automatic test_redirect_full;
      @(negedge clk);
      rst_n = 1'b0; memLat = 1; Stall_F = 1'b1; redirect = 1'b0; imem_ready = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      #1;
      if ({validF, PCF, imem_req} !== {1'b1, 32'h0, 1'b0}) begin
         nFail++; $display("FAIL full_before: got v=%b pc=%h req=%b want 1/00000000/0", validF, PCF, imem_req);
      end
      nTests++;
      redirect = 1'b1; redirect_pc = 32'h203; #1;
      if ({validF, imem_req, instrF} !== {1'b0, 1'b0, NOP}) begin
         nFail++; $display("FAIL full_redir: got v=%b req=%b i=%h want 0/0/%h", validF, imem_req, instrF, NOP);
      end
      nTests++;
      @(negedge clk); redirect = 1'b0; Stall_F = 1'b0; #1;
      if ({imem_req, imem_addr, validF} !== {1'b1, 32'h200, 1'b0}) begin
         nFail++; $display("FAIL full_req200: got %b/%h v=%b want 1/00000200 v=0", imem_req, imem_addr, validF);
      end
      nTests++;
      @(negedge clk); #1;
      if ({imem_req, imem_addr, validF} !== {1'b1, 32'h204, 1'b0}) begin
         nFail++; $display("FAIL full_req204: got %b/%h v=%b want 1/00000204 v=0", imem_req, imem_addr, validF);
      end
      nTests++;
      @(negedge clk); #1;
      if ({validF, PCF, PCp4F, instrF, imem_addr} !== {1'b1, 32'h200, 32'h204, instr_of(32'h200), 32'h208}) begin
         nFail++; $display("FAIL full_first: got v=%b pc=%h p4=%h i=%h a=%h want pc=00000200 a=00000208", validF, PCF, PCp4F, instrF, imem_addr);
      end
      nTests++;
   endtask

   task automatic test_ready_low;
      int acc0;
      acc0 = accCnt;
      imem_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) begin @(negedge clk); #1; end
         if ({imem_req, imem_addr} !== {1'b1, 32'h208}) begin
            nFail++; $display("FAIL rdy_hold[%0d]: got %b/%h want 1/00000208", i, imem_req, imem_addr);
         end
         nTests++;
         if (i == 1) begin
            if ({validF, PCF} !== {1'b1, 32'h204}) begin nFail++; $display("FAIL rdy_drain: got v=%b pc=%h want 1/00000204", validF, PCF); end
            nTests++;
         end else if (i > 1) begin
            if (validF !== 1'b0) begin nFail++; $display("FAIL rdy_empty[%0d]: got v=%b want 0", i, validF); end
            nTests++;
         end
      end
      @(negedge clk); imem_ready = 1'b1; #1;
      if ({imem_req, imem_addr} !== {1'b1, 32'h208}) begin nFail++; $display("FAIL rdy_release: got %b/%h want 1/00000208", imem_req, imem_addr); end
      nTests++;
      @(negedge clk); #1;
      if (accCnt - acc0 != 1) begin nFail++; $display("FAIL rdy_accepts: got %0d want 1", accCnt - acc0); end
      nTests++;
      @(negedge clk); #1;
      if ({validF, PCF, instrF} !== {1'b1, 32'h208, instr_of(32'h208)}) begin nFail++; $display("FAIL rdy_pc208: got v=%b pc=%h want 00000208", validF, PCF); end
      nTests++;
      @(negedge clk); #1;
      if ({validF, PCF, instrF} !== {1'b1, 32'h20C, instr_of(32'h20C)}) begin nFail++; $display("FAIL rdy_pc20c: got v=%b pc=%h want 0000020c", validF, PCF); end
      nTests++;
   endtask

   task automatic test_wrap_reset;
      @(negedge clk);
      rst_n = 1'b0; Stall_F = 1'b0; imem_ready = 1'b1; memLat = 1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
      @(negedge clk); redirect = 1'b0; #1;
      if ({imem_req, imem_addr} !== {1'b1, 32'hFFFF_FFF8}) begin nFail++; $display("FAIL wrap_a0: got %b/%h want 1/fffffff8", imem_req, imem_addr); end
      nTests++;
      @(negedge clk); #1;
      if ({imem_req, imem_addr} !== {1'b1, 32'hFFFF_FFFC}) begin nFail++; $display("FAIL wrap_a1: got %b/%h want 1/fffffffc", imem_req, imem_addr); end
      nTests++;
      @(negedge clk); #1;
      if ({imem_req, imem_addr, PCF, PCp4F} !== {1'b1, 32'h0, 32'hFFFF_FFF8, 32'hFFFF_FFFC}) begin
         nFail++; $display("FAIL wrap_a2: got %b/%h pc=%h p4=%h want 1/00000000 pc=fffffff8", imem_req, imem_addr, PCF, PCp4F);
      end
      nTests++;
      @(negedge clk); #1;
      if ({validF, PCF, PCp4F, instrF} !== {1'b1, 32'hFFFF_FFFC, 32'h0, instr_of(32'hFFFF_FFFC)}) begin
         nFail++; $display("FAIL wrap_p4: got v=%b pc=%h p4=%h i=%h want pc=fffffffc p4=00000000", validF, PCF, PCp4F, instrF);
      end
      nTests++;
      #1 rst_n = 1'b0;
      #1;
      if ({imem_req, validF, instrF, PCF, PCp4F} !== {1'b0, 1'b0, NOP, 32'h0, 32'h0}) begin
         nFail++; $display("FAIL async_reset: got req=%b v=%b i=%h pc=%h p4=%h want 0/0/%h/0/0", imem_req, validF, instrF, PCF, PCp4F, NOP);
      end
      nTests++;
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_redirect_drop();
      test_redirect_full();
      test_ready_low();
      test_wrap_reset();
      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

   initial begin
      #200000;
      nFail++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $fatal(1, "watchdog");
   end

endmodule
